// File: rtl/tanimoto_run_ctrl.sv
// tanimoto_run_ctrl
// Sequences one tanimoto_top run:
//   1. stream the per-popcount threshold table into the BRAM (addresses 0..VECTOR_WIDTH-1),
//   2. program the compare-vector count (valid/wack handshake),
//   3. gate exactly (SHR_DEPTH + CmpVectorNo) * SUB_VECTOR_NO beats from the vector FIFO,
//   4. wait for the last ID pair (or time out), then pulse o_Done.
// Ports:
//   clk, rst                    clock, async active-high reset
//   i_Start, i_CmpVectorNo      run request (sampled in IDLE) and its compare count
//   i_ThrData/Valid, o_ThrReady threshold table stream
//   o_BRAM_*                    registered BRAM write port toward tanimoto_top
//   o_CmpVectorNo/Valid, i_CmpVectorNoWack  compare-count programming
//   i_SrcEmpty, o_SrcRead       vector FIFO side
//   o_DutValid, i_DutRead       datapath beat handshake
//   i_IDPairReady/Read/Last     result stream monitor
//   o_Busy, o_Done, o_Error     run status (o_Error sticky until next start)
module tanimoto_run_ctrl #(
    parameter int VECTOR_WIDTH  = 920,
    parameter int SUB_VECTOR_NO = 2,
    parameter int SHR_DEPTH     = 8,
    parameter int VEC_ID_WIDTH  = $clog2(VECTOR_WIDTH),
    parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH),
    parameter int BEAT_WIDTH    = VEC_ID_WIDTH + $clog2(SUB_VECTOR_NO) + 1,
    parameter int TIMEOUT       = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_Start,
    input  logic [VEC_ID_WIDTH-1:0] i_CmpVectorNo,
    input  logic [CNT_WIDTH:0]      i_ThrData,
    input  logic                    i_ThrValid,
    output logic                    o_ThrReady,
    output logic [CNT_WIDTH-1:0]    o_BRAM_Addr,
    output logic [CNT_WIDTH:0]      o_BRAM_Din,
    output logic                    o_BRAM_En,
    output logic                    o_BRAM_WrEn,
    output logic [VEC_ID_WIDTH-1:0] o_CmpVectorNo,
    output logic                    o_CmpVectorNoValid,
    input  logic                    i_CmpVectorNoWack,
    input  logic                    i_SrcEmpty,
    output logic                    o_SrcRead,
    output logic                    o_DutValid,
    input  logic                    i_DutRead,
    input  logic                    i_IDPairReady,
    input  logic                    i_IDPairRead,
    input  logic                    i_IDPairLast,
    output logic                    o_Busy,
    output logic                    o_Done,
    output logic                    o_Error
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_THR, S_SET_CMPNO, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [VEC_ID_WIDTH-1:0] cmp_no;
    logic [BEAT_WIDTH-1:0]   total;
    logic [BEAT_WIDTH-1:0]   beat_cnt;
    logic [CNT_WIDTH-1:0]    addr_cnt;
    logic [IDLE_W-1:0]       idle_cnt;
    logic                    last_seen;
    logic                    error_q;
    logic                    bram_en_q;
    logic [CNT_WIDTH-1:0]    bram_addr_q;
    logic [CNT_WIDTH:0]      bram_din_q;

    logic thr_hs, thr_last, src_rd, beat_last, id_hs, id_last, idle_expire;

    assign thr_hs      = (state == S_LOAD_THR) & i_ThrValid;
    assign thr_last    = thr_hs & (addr_cnt == CNT_WIDTH'(VECTOR_WIDTH - 1));
    assign src_rd      = (state == S_STREAM) & i_DutRead & ~i_SrcEmpty;
    assign beat_last   = src_rd & ((beat_cnt + BEAT_WIDTH'(1)) == total);
    assign id_hs       = i_IDPairReady & i_IDPairRead;
    assign id_last     = id_hs & i_IDPairLast;
    // Any ID-pair handshake proves the result stream is alive and restarts the idle count.
    assign idle_expire = ~id_hs & ((idle_cnt + IDLE_W'(1)) == IDLE_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        o_ThrReady         = 1'b0;
        o_CmpVectorNoValid = 1'b0;
        o_DutValid         = 1'b0;
        o_SrcRead          = 1'b0;
        o_Done             = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_Start) state_nxt = S_LOAD_THR;
            end
            S_LOAD_THR: begin
                o_ThrReady = 1'b1;
                if (thr_last) state_nxt = S_SET_CMPNO;
            end
            S_SET_CMPNO: begin
                o_CmpVectorNoValid = 1'b1;
                if (i_CmpVectorNoWack) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                o_DutValid = ~i_SrcEmpty;
                o_SrcRead  = src_rd;
                if (beat_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // A last handshake seen while streaming lets the drain finish immediately.
                if (last_seen || id_last || idle_expire) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_Done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_no    <= '0;
            total     <= '0;
            beat_cnt  <= '0;
            addr_cnt  <= '0;
            idle_cnt  <= '0;
            last_seen <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        cmp_no    <= i_CmpVectorNo;
                        total     <= (BEAT_WIDTH'(SHR_DEPTH) + BEAT_WIDTH'(i_CmpVectorNo))
                                     * BEAT_WIDTH'(SUB_VECTOR_NO);
                        error_q   <= 1'b0;
                        beat_cnt  <= '0;
                        addr_cnt  <= '0;
                        idle_cnt  <= '0;
                        last_seen <= 1'b0;
                    end
                end
                S_LOAD_THR: begin
                    if (thr_hs) addr_cnt <= thr_last ? '0 : addr_cnt + CNT_WIDTH'(1);
                end
                S_STREAM: begin
                    if (src_rd)  beat_cnt  <= beat_cnt + BEAT_WIDTH'(1);
                    if (id_last) last_seen <= 1'b1;
                end
                S_DRAIN: begin
                    idle_cnt <= id_hs ? '0 : idle_cnt + IDLE_W'(1);
                    if (!last_seen && !id_last && idle_expire) error_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // BRAM write port is registered: a handshake shows up as a write one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            bram_en_q <= thr_hs;
            if (thr_hs) begin
                bram_addr_q <= addr_cnt;
                bram_din_q  <= i_ThrData;
            end
        end
    end

    assign o_BRAM_En     = bram_en_q;
    assign o_BRAM_WrEn   = bram_en_q;
    assign o_BRAM_Addr   = bram_addr_q;
    assign o_BRAM_Din    = bram_din_q;
    assign o_CmpVectorNo = cmp_no;
    assign o_Busy        = (state != S_IDLE);
    assign o_Error       = error_q;

endmodule
